// File: rtl/mux81_rr_sched_pkg.sv
// Shared constants and types for the mux81 round-robin scheduler.
// NREQ/SELW are fixed by the mux81 datapath (8 inputs, 3 select pins).
package mux81_rr_sched_pkg;

    localparam int NREQ = 8;
    localparam int SELW = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Next requester index after v, wrapping 7 -> 0.
    function automatic logic [SELW-1:0] next_idx(input logic [SELW-1:0] v);
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/mux81_rr_sched_rr_pick8.sv
// Combinational round-robin picker: finds the first asserted request
// searching upward from ptr (mod 8).
module rr_pick8
    import mux81_rr_sched_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic            hit,
    output logic [SELW-1:0] idx
);

    logic [NREQ-1:0] w_rot;
    logic [SELW-1:0] w_off;

    // Rotate so that requester ptr lands at bit 0, then the lowest set bit wins.
    assign w_rot = NREQ'({req, req} >> ptr);

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = SELW'(k);
        end
    end

    assign hit = |req;
    assign idx = w_off + ptr;

endmodule

// File: rtl/mux81_rr_sched.sv
// Round-robin scheduler sharing one 8:1 mux among 8 requesters, with a
// bounded burst per owner and registered select/grant/valid outputs.
module mux81_rr_sched
    import mux81_rr_sched_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int CNTW      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic            s2,
    output logic            s1,
    output logic            s0,
    output logic [NREQ-1:0] gnt,
    output logic            valid
);

    state_t          r_state;
    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] r_sel;
    logic [CNTW-1:0] r_cnt;
    logic [NREQ-1:0] r_gnt;
    logic            r_valid;

    logic            w_release;
    logic [SELW-1:0] w_pick_ptr;
    logic            w_hit;
    logic [SELW-1:0] w_idx;

    // r_sel doubles as the owner index while in GRANT.
    assign w_release  = (r_state == ST_GRANT) &&
                        (!req[r_sel] || (r_cnt == CNTW'(MAX_BURST - 1)));
    // On release the pointer moves past the owner before re-picking, so the
    // owner becomes lowest priority on the same edge.
    assign w_pick_ptr = (r_state == ST_GRANT) ? next_idx(r_sel) : r_ptr;

    rr_pick8 u_pick (
        .req (req),
        .ptr (w_pick_ptr),
        .hit (w_hit),
        .idx (w_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        r_state <= ST_GRANT;
                        r_sel   <= w_idx;
                        r_gnt   <= NREQ'(1) << w_idx;
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_ptr <= w_pick_ptr;
                        if (w_hit) begin
                            r_sel   <= w_idx;
                            r_gnt   <= NREQ'(1) << w_idx;
                            r_valid <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            // r_sel is deliberately left at the last owner.
                            r_state <= ST_IDLE;
                            r_gnt   <= '0;
                            r_valid <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign {s2, s1, s0} = r_sel;
    assign gnt          = r_gnt;
    assign valid        = r_valid;

endmodule

// File: tb/tb_mux81_rr_sched.sv
// Self-checking bench for mux81_rr_sched against a behavioural round-robin model.
module tb_mux81_rr_sched;

    localparam int BURST = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       s2, s1, s0;
    logic [7:0] gnt;
    logic       valid;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: owner (-1 = none), cycles held so far, search start, last select.
    int         m_owner = -1;
    int         m_held  = 0;
    int         m_ptr   = 0;
    int         m_sel   = 0;
    logic [7:0] exp_gnt;
    logic       exp_valid;
    logic [2:0] exp_sel;

    logic [7:0] mux_in;

    mux81_rr_sched #(.MAX_BURST(BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .s2    (s2),
        .s1    (s1),
        .s0    (s0),
        .gnt   (gnt),
        .valid (valid)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_sel   = 0;
    endtask

    task automatic model_outputs();
        exp_valid = (m_owner >= 0);
        exp_gnt   = exp_valid ? (8'h01 << m_owner) : 8'h00;
        exp_sel   = 3'(m_sel);
    endtask

    // Advance the model by one clock edge with request vector r.
    task automatic model_edge(input logic [7:0] r);
        int k;
        if (!rst_n) begin
            model_reset();
        end else if (m_owner < 0) begin
            k = pick(r, m_ptr);
            if (k >= 0) begin
                m_owner = k; m_held = 1; m_sel = k;
            end
        end else if (!r[m_owner] || m_held == BURST) begin
            m_ptr = (m_owner + 1) % 8;
            k = pick(r, m_ptr);
            if (k >= 0) begin
                m_owner = k; m_held = 1; m_sel = k;
            end else begin
                m_owner = -1;
            end
        end else begin
            m_held++;
        end
        model_outputs();
    endtask

    // Drive req, take one clock edge, update the model, settle past the edge.
    task automatic cycle(input logic [7:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
    endtask

    // Every-cycle invariants plus a behavioural mux81 fed with a random sweep.
    always @(negedge clk) begin
        logic y;
        int   gi;
        if (rst_n) begin
            mux_in = 8'($urandom);
            y = mux_in[{s2, s1, s0}];
            n_checks++;
            if ($countones(gnt) > 1 || valid !== (|gnt)) begin
                n_errors++;
                $display("FAIL invariant: gnt=%02h valid=%0b required one-hot/zero gnt with valid==|gnt", gnt, valid);
            end
            if (valid === 1'b1) begin
                gi = 0;
                for (int k = 0; k < 8; k++) if (gnt[k]) gi = k;
                n_checks++;
                if (y !== mux_in[gi]) begin
                    n_errors++;
                    $display("FAIL mux_route: y=%0b sel=%0d required i[%0d]=%0b", y, {s2, s1, s0}, gi, mux_in[gi]);
                end
            end
        end
    end

    task automatic test_reset();
        model_reset();
        model_outputs();
        for (int c = 0; c < 3; c++) begin
            cycle(8'hFF);
            n_checks++;
            if (gnt !== 8'h00 || valid !== 1'b0 || {s2, s1, s0} !== 3'd0) begin
                n_errors++;
                $display("FAIL reset_hold: gnt=%02h valid=%0b sel=%0d required 00/0/0", gnt, valid, {s2, s1, s0});
            end
        end
        rst_n = 1'b1;
        cycle(8'hFF);
        n_checks++;
        if (gnt !== 8'h01 || valid !== 1'b1 || {s2, s1, s0} !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_first: gnt=%02h valid=%0b sel=%0d required 01/1/0", gnt, valid, {s2, s1, s0});
        end
        $display("test_reset done: gnt=%02h", gnt);
    endtask

    task automatic test_single();
        cycle(8'h00);
        for (int c = 0; c < 40; c++) begin
            cycle(8'h20);
            n_checks++;
            if (gnt !== 8'h20 || valid !== 1'b1 || {s2, s1, s0} !== 3'b101 ||
                gnt !== exp_gnt) begin
                n_errors++;
                $display("FAIL single_req c=%0d: gnt=%02h valid=%0b sel=%0d required 20/1/5", c, gnt, valid, {s2, s1, s0});
            end
        end
        $display("test_single done: 40 cycles owner 5");
    endtask

    task automatic test_rotation();
        int changes = 0;
        logic [7:0] prev;
        prev = gnt;
        for (int c = 0; c < 8 * BURST + 20; c++) begin
            cycle(8'hFF);
            if (gnt !== prev) changes++;
            prev = gnt;
            n_checks++;
            if (gnt !== exp_gnt || valid !== 1'b1 || {s2, s1, s0} !== exp_sel) begin
                n_errors++;
                $display("FAIL rotation c=%0d: gnt=%02h valid=%0b sel=%0d required %02h/1/%0d", c, gnt, valid, {s2, s1, s0}, exp_gnt, exp_sel);
            end
        end
        n_checks++;
        if (changes < 8 || changes > 10) begin
            n_errors++;
            $display("FAIL rotation_changes: %0d owner changes required 8..10", changes);
        end
        $display("test_rotation done: %0d owner changes", changes);
    endtask

    task automatic test_early_release();
        cycle(8'h00);
        cycle(8'h08);
        for (int c = 0; c < 4; c++) cycle(8'h4A);
        n_checks++;
        if (gnt !== 8'h08) begin
            n_errors++;
            $display("FAIL early_owner3: gnt=%02h required 08", gnt);
        end
        cycle(8'h42);
        n_checks++;
        if (gnt !== 8'h40 || valid !== 1'b1 || {s2, s1, s0} !== 3'd6 || gnt !== exp_gnt) begin
            n_errors++;
            $display("FAIL early_next: gnt=%02h valid=%0b sel=%0d required 40/1/6", gnt, valid, {s2, s1, s0});
        end
        $display("test_early_release done: gnt=%02h", gnt);
    endtask

    task automatic test_drain();
        cycle(8'h00);
        n_checks++;
        if (gnt !== 8'h00 || valid !== 1'b0 || {s2, s1, s0} !== 3'd6) begin
            n_errors++;
            $display("FAIL drain_idle: gnt=%02h valid=%0b sel=%0d required 00/0/6", gnt, valid, {s2, s1, s0});
        end
        cycle(8'h00);
        cycle(8'h04);
        n_checks++;
        if (gnt !== 8'h04 || valid !== 1'b1 || {s2, s1, s0} !== 3'd2) begin
            n_errors++;
            $display("FAIL drain_regrant: gnt=%02h valid=%0b sel=%0d required 04/1/2", gnt, valid, {s2, s1, s0});
        end
        $display("test_drain done: gnt=%02h", gnt);
    endtask

    task automatic test_async_reset();
        cycle(8'h00);
        for (int c = 0; c < 4; c++) cycle(8'h20);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        model_outputs();
        n_checks++;
        if (gnt !== 8'h00 || valid !== 1'b0 || {s2, s1, s0} !== 3'd0) begin
            n_errors++;
            $display("FAIL async_reset: gnt=%02h valid=%0b sel=%0d required 00/0/0", gnt, valid, {s2, s1, s0});
        end
        cycle(8'hFF);
        rst_n = 1'b1;
        cycle(8'hFF);
        n_checks++;
        if (gnt !== 8'h01 || {s2, s1, s0} !== 3'd0) begin
            n_errors++;
            $display("FAIL async_first: gnt=%02h sel=%0d required 01/0", gnt, {s2, s1, s0});
        end
        $display("test_async_reset done: gnt=%02h", gnt);
    endtask

    task automatic test_random();
        logic [7:0] r;
        int hold;
        for (int t = 0; t < 60; t++) begin
            r = 8'($urandom) & 8'($urandom);
            hold = $urandom_range(1, 24);
            for (int c = 0; c < hold; c++) begin
                if ($urandom_range(0, 7) == 0) r = r ^ (8'h01 << $urandom_range(0, 7));
                cycle(r);
                n_checks++;
                if (gnt !== exp_gnt || valid !== exp_valid || {s2, s1, s0} !== exp_sel) begin
                    n_errors++;
                    $display("FAIL random t=%0d req=%02h: gnt=%02h valid=%0b sel=%0d required %02h/%0b/%0d",
                             t, r, gnt, valid, {s2, s1, s0}, exp_gnt, exp_valid, exp_sel);
                end
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_early_release();
        test_drain();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
